// File: rtl/gate_pkg.sv
// Shared op codes and helpers for the configurable N-input bitwise gate datapath.
package gate_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
    localparam logic [OP_W-1:0] OP_NAND = 3'd3;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_XNOR);
    endfunction

endpackage

// File: rtl/gate_fn.sv
// Combinational bitwise function across NUM_IN channels of WIDTH bits each.
module gate_fn
    import gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3
) (
    input  logic [OP_W-1:0]         op,
    input  logic [NUM_IN*WIDTH-1:0] data,
    output logic [WIDTH-1:0]        result,
    output logic                    err
);

    logic [WIDTH-1:0] and_s;
    logic [WIDTH-1:0] or_s;
    logic [WIDTH-1:0] xor_s;

    // Reduce all channels per bit, then pick the requested function.
    always_comb begin
        and_s = {WIDTH{1'b1}};
        or_s  = {WIDTH{1'b0}};
        xor_s = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_IN; i++) begin
            and_s = and_s & data[i*WIDTH +: WIDTH];
            or_s  = or_s  | data[i*WIDTH +: WIDTH];
            xor_s = xor_s ^ data[i*WIDTH +: WIDTH];
        end
        err = !is_legal_op(op);
        case (op)
            OP_AND:  result = and_s;
            OP_OR:   result = or_s;
            OP_XOR:  result = xor_s;
            OP_NAND: result = ~and_s;
            OP_NOR:  result = ~or_s;
            OP_XNOR: result = ~xor_s;
            default: result = {WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/multi_gate_pipe.sv
// Two-stage valid/ready pipeline applying a selectable bitwise function across NUM_IN channels.
module multi_gate_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int NUM_IN = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_W-1:0]         in_op,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_any,
    output logic                    out_all,
    output logic                    out_err,
    output logic [CNT_W-1:0]        txn_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic                    s1_valid_q, s1_valid_d;
    logic [OP_W-1:0]         s1_op_q, s1_op_d;
    logic [NUM_IN*WIDTH-1:0] s1_data_q, s1_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_data_q, out_data_d;
    logic                    out_any_q, out_any_d;
    logic                    out_all_q, out_all_d;
    logic                    out_err_q, out_err_d;
    logic [CNT_W-1:0]        txn_count_q, txn_count_d;

    logic                    s2_load_s;
    logic                    in_accept_s;
    logic                    out_xfer_s;
    logic [WIDTH-1:0]        fn_result_s;
    logic                    fn_err_s;

    gate_fn #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_gate_fn (
        .op     (s1_op_q),
        .data   (s1_data_q),
        .result (fn_result_s),
        .err    (fn_err_s)
    );

    // in_ready follows out_ready combinationally so a draining output frees a slot the same cycle.
    assign s2_load_s   = s1_valid_q && (!out_valid_q || out_ready);
    assign in_ready    = !s1_valid_q || s2_load_s;
    assign in_accept_s = in_valid && in_ready;
    assign out_xfer_s  = out_valid_q && out_ready;

    // Next-state for both stages and the transfer counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_op_d     = s1_op_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_any_d   = out_any_q;
        out_all_d   = out_all_q;
        out_err_d   = out_err_q;
        txn_count_d = txn_count_q;

        if (in_accept_s) begin
            s1_valid_d = 1'b1;
            s1_op_d    = in_op;
            s1_data_d  = in_data;
        end else if (s2_load_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (s2_load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = fn_result_s;
            out_any_d   = |fn_result_s;
            out_all_d   = &fn_result_s;
            out_err_d   = fn_err_s;
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_xfer_s) begin
            txn_count_d = txn_count_q + CNT_ONE;
        end else begin
            txn_count_d = txn_count_q;
        end
    end

    // Pipeline state registers; reset clears everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= {OP_W{1'b0}};
            s1_data_q   <= {(NUM_IN*WIDTH){1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            out_any_q   <= 1'b0;
            out_all_q   <= 1'b0;
            out_err_q   <= 1'b0;
            txn_count_q <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_op_q     <= s1_op_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_any_q   <= out_any_d;
            out_all_q   <= out_all_d;
            out_err_q   <= out_err_d;
            txn_count_q <= txn_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_any   = out_any_q;
    assign out_all   = out_all_q;
    assign out_err   = out_err_q;
    assign txn_count = txn_count_q;

endmodule
